// File: rtl/sipo_frame_rx_if.sv
// rtl/sipo_frame_rx_if.sv - serial line and parallel word bundle for sipo_frame_rx
// Purpose: groups the serial input side and the parallel valid/ready output side.
// Signals:
//   sin        serial line, idle high
//   bit_en     bit strobe; sin is sampled only when high
//   dout       received word
//   dout_valid word available
//   dout_ready consumer accepts the word
//   frame_err  one-clk pulse on a bad stop bit
//   overrun    sticky dropped-word flag
//   busy       frame reception in progress
// Modports: master drives the line and ready; slave is the receiver.
interface sipo_frame_rx_if #(
  parameter int WIDTH = 4
);
  logic             sin;
  logic             bit_en;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             frame_err;
  logic             overrun;
  logic             busy;

  modport master (
    output sin, bit_en, dout_ready,
    input  dout, dout_valid, frame_err, overrun, busy
  );

  modport slave (
    input  sin, bit_en, dout_ready,
    output dout, dout_valid, frame_err, overrun, busy
  );
endinterface

// File: rtl/sipo_frame_rx.sv
// rtl/sipo_frame_rx.sv - serial-to-parallel frame receiver with framing and overrun errors
// Purpose: detects a start bit on an idle-high line, shifts in WIDTH data bits,
//   checks the stop bit and presents the word on a valid/ready interface.
// Ports:
//   clk  rising-edge clock
//   clr  asynchronous active-low reset
//   bus  sipo_frame_rx_if.slave (sin, bit_en, dout_ready in; dout, dout_valid,
//        frame_err, overrun, busy out)
module sipo_frame_rx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic               clk,
  input  logic               clr,
  sipo_frame_rx_if.slave     bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    // frame_err is a single-clock pulse, so it clears on every edge by default
    ferr_d  = 1'b0;

    // The handshake runs on every clock, independent of the bit strobe.
    if (valid_q && bus.dout_ready) begin
      valid_d = 1'b0;
    end

    if (bus.bit_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!bus.sin) begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end
        end
        ST_DATA: begin
          if (MSB_FIRST) begin
            shift_d = {shift_q[WIDTH-2:0], bus.sin};
          end else begin
            shift_d = {bus.sin, shift_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = ST_STOP;
          end
        end
        ST_STOP: begin
          if (bus.sin) begin
            state_d = ST_IDLE;
            // A word still held without an accept this edge is kept; the new one is lost.
            if (valid_q && !bus.dout_ready) begin
              ovr_d = 1'b1;
            end else begin
              dout_d  = shift_q;
              valid_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end
        ST_BREAK: begin
          // A line held low must return high before another start bit counts.
          if (bus.sin) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule
